// File: rtl/cic_sample_uart.sv
// ============================================================================
// cic_sample_uart - buffers decimated CIC samples in a small FIFO and sends
// each one as an 8N1 UART frame (8E1 when CIC_UART_PARITY_EN is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cic_sample_uart #(
  parameter int CLK_PER_BIT = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_clk,
  input  logic [6:0]                    sample_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [7:0] c_cyc_last = 8'(CLK_PER_BIT - 1);

`ifdef CIC_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_t;
`endif

  state_t            r_state;
  logic              r_sc_q;
  logic [6:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_level;
  logic              r_overflow;
  logic [7:0]        r_shift;
  logic [7:0]        r_cyc;
  logic [2:0]        r_bit;
  logic              r_tx;
  logic              r_busy;
`ifdef CIC_UART_PARITY_EN
  logic              r_par;
`endif

  logic              w_capture;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [6:0]        w_head;
  logic              w_bit_end;

  assign w_capture = sample_clk & ~r_sc_q;
  assign w_full    = (r_level == c_depth);
  assign w_pop     = (r_state == ST_IDLE) && (r_level != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_bit_end = (r_cyc == c_cyc_last);

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_q     <= sample_clk;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sc_q <= sample_clk;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_capture && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef CIC_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cyc <= '0;
          r_bit <= '0;
          if (w_pop) begin
            r_shift <= {1'b0, w_head};
`ifdef CIC_UART_PARITY_EN
            r_par   <= ^w_head;
`endif
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == 3'd7) begin
              r_bit <= '0;
`ifdef CIC_UART_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
`ifdef CIC_UART_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_sample_uart.sv
// ============================================================================
// tb_cic_sample_uart - directed self-checking bench, CLK_PER_BIT=4, FIFO_DEPTH=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cic_sample_uart;

  localparam int CPB = 4;
`ifdef CIC_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       sample_clk;
  logic [6:0] sample_in;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_checks;
  int n_fail;
  logic [6:0] seq [6];

  cic_sample_uart #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .sample_in  (sample_in),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in the cycle after the capture edge (E+1).
  task automatic cap(input logic [6:0] val);
    sample_in  = val;
    sample_clk = 1'b1;
    step(1);
    sample_clk = 1'b0;
  endtask

  // Entered in the first start-bit cycle; returns in the idle cycle after stop.
  task automatic rx_frame(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    got = '0;
    step(2);
    check({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      got[i] = tx;
    end
    check({tag, "_data"}, 32'(got), 32'(exp));
`ifdef CIC_UART_PARITY_EN
    step(CPB);
    check({tag, "_parity"}, 32'(tx), 32'(^exp));
`endif
    step(CPB);
    check({tag, "_stop"}, 32'(tx), 32'd1);
    step(1);
    check({tag, "_busy_last"}, 32'(busy), 32'd1);
    step(1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nt;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    sample_clk = 1'b0;
    sample_in  = '0;
    seq[0] = 7'h11; seq[1] = 7'h22; seq[2] = 7'h33;
    seq[3] = 7'h44; seq[4] = 7'h55; seq[5] = 7'h66;
    step(3);
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    step(2);

    // single capture, latency and 0x55 frame
    cap(7'h55);
    check("e1_level", 32'(fifo_level), 32'd1);
    check("e1_tx", 32'(tx), 32'd1);
    step(1);
    check("e2_tx", 32'(tx), 32'd0);
    check("e2_busy", 32'(busy), 32'd1);
    check("e2_level", 32'(fifo_level), 32'd0);
    rx_frame(8'h55, "f55");

    // six captures two cycles apart: one popped, four stored, one dropped
    step(3);
    for (int k = 0; k < 6; k++) begin
      cap(seq[k]);
      step(1);
    end
    check("burst_level", 32'(fifo_level), 32'd4);
    check("burst_ovf", 32'(overflow), 32'd1);
    wait_idle("burst_first_done");
    for (int k = 1; k < 5; k++) begin
      step(1);
      check("burst_gap_start", 32'(tx), 32'd0);
      rx_frame({1'b0, seq[k]}, "burst");
    end
    nb = 0;
    repeat (60) begin
      step(1);
      if (busy) nb++;
    end
    check("burst_no_sixth", 32'(nb), 32'd0);
    check("burst_level_end", 32'(fifo_level), 32'd0);

    // capture during STOP of previous frame
    cap(7'h0A);
    step(1);
    step((FB - 1) * CPB + 1);
    cap(7'h35);
    check("stop_cap_level", 32'(fifo_level), 32'd1);
    check("stop_cap_busy", 32'(busy), 32'd1);
    step(CPB - 2);
    check("gap_tx", 32'(tx), 32'd1);
    check("gap_busy", 32'(busy), 32'd0);
    step(1);
    check("gap_next_start", 32'(tx), 32'd0);
    check("gap_next_level", 32'(fifo_level), 32'd0);
    rx_frame(8'h35, "f35");

    // reset at cycle 15 of a frame with one sample queued
    cap(7'h3C);
    step(1);
    step(3);
    cap(7'h01);
    check("abort_level_pre", 32'(fifo_level), 32'd1);
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    nb = 0;
    nt = 0;
    repeat (60) begin
      step(1);
      if (busy) nb++;
      if (!tx) nt++;
    end
    check("abort_quiet_busy", 32'(nb), 32'd0);
    check("abort_quiet_tx", 32'(nt), 32'd0);

    // sample_clk already high at reset release must not capture
    sample_in  = 7'h2A;
    sample_clk = 1'b1;
    rst        = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);
    check("hold_level", 32'(fifo_level), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    sample_clk = 1'b0;
    step(1);
    cap(7'h2A);
    check("hold_cap_level", 32'(fifo_level), 32'd1);
    step(1);
    check("hold_start", 32'(tx), 32'd0);
    rx_frame(8'h2A, "f2a");

    // parity patterns (odd and even weight)
    step(2);
    cap(7'h07);
    step(1);
    rx_frame(8'h07, "f07");
    step(2);
    cap(7'h03);
    step(1);
    rx_frame(8'h03, "f03");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cic_sample_uart.md
CIC_SAMPLE_UART -- requirements
Module: cic_sample_uart

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 8, meaning clock cycles per UART bit (legal range 2..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning sample FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sample_clk, input, 1 bit: decimated-rate toggle from the upstream decimator, same clock domain as clk.
REQ-006 The block SHALL have port sample_in, input, 7 bits: decimated sample word, valid when sample_clk rises.
REQ-007 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on tx.
REQ-009 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current number of stored samples.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag set when a sample is dropped.

Function
REQ-011 Rising-edge detect: register sc_q <= sample_clk every cycle; cycle E is a capture cycle when sample_clk=1 and sc_q=0.
REQ-012 On capture cycle E, sample_in SHALL be written into the FIFO at the end of E, unless the FIFO is full and no pop occurs in E.
REQ-013 Write to a full FIFO with simultaneous pop SHALL be accepted; write to a full FIFO without pop SHALL be dropped and set overflow=1.
REQ-014 overflow SHALL stay 1 until rst; fifo_level SHALL equal writes minus pops and never exceed FIFO_DEPTH.
REQ-015 Transmit FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx=1, busy=0; if fifo_level!=0, pop the head, load shift register with byte {1'b0, sample[6:0]}, and go to START.
REQ-017 START: tx=0 for CLK_PER_BIT cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each CLK_PER_BIT cycles, then PARITY or STOP per REQ-026/027.
REQ-019 STOP: tx=1 for CLK_PER_BIT cycles, then IDLE; busy deasserts when IDLE is entered.
REQ-020 tx and busy SHALL be registered and change on the same edge as the state register.
REQ-021 Latency: for an empty FIFO and IDLE FSM, the pop occurs in E+1, and tx=0, busy=1 are first visible in cycle E+2.
REQ-022 A FIFO that becomes non-empty in the STOP phase SHALL be popped in the first IDLE cycle; back-to-back frames are separated by exactly one idle cycle (tx=1).
REQ-023 The bit counter and the per-bit cycle counter SHALL wrap cleanly; frame length is exactly (10 or 11)*CLK_PER_BIT cycles.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL set tx=1, busy=0, fifo_level=0, overflow=0, state=IDLE, all counters to 0, and sc_q<=sample_clk, so that a sample_clk already high at reset release does not cause a capture; FIFO contents are discarded.
REQ-025 rst asserted mid-frame SHALL abort the frame: tx=1 from the cycle after the rst edge; no partial frame resumes.

Configuration
REQ-026 With macro CIC_UART_PARITY_EN defined, PARITY state SHALL follow DATA and send even parity (XOR of 8 data bits) for CLK_PER_BIT cycles; frame = 11 bits.
REQ-027 Without CIC_UART_PARITY_EN, PARITY state and logic SHALL be absent, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single capture sample_in=0x55 -> tx=0 at E+2, then data 1,0,1,0,1,0,1,0, stop 1; busy high 40 cycles (no parity).
REQ-029 Six captures 2 cycles apart while idle -> first popped at E+1, next four stored (fifo_level=4), sixth dropped, overflow=1; exactly 5 frames emitted, in order.
REQ-030 rst asserted at cycle 15 of a frame -> tx=1, busy=0, fifo_level=0 next cycle; no further frames without new captures.
REQ-031 sample_clk held high through rst release -> no capture, fifo_level stays 0 until sample_clk goes low then high.
REQ-032 With CIC_UART_PARITY_EN, sample 0x07 -> parity bit 1, frame 44 cycles; sample 0x03 -> parity bit 0.
REQ-033 Capture arriving during STOP of previous frame -> next start bit begins after exactly one tx=1 idle cycle.
